regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the regfile's single write port between two writers:
//   - the pipeline WB stage (primary; the pipeline never waits for it);
//   - the long-latency unit LU (secondary; valid/ready handshake).
//  LU results are buffered in a small FIFO, and the FIFO drains into the write port when WB is idle.
//  Keeps a 32-bit scoreboard of registers awaiting an LU result; the hazard unit uses it to stall readers.
// PARAMETERS
//  DATA_W      64  write data width
//  ADDR_W      5   register address width
//  DEPTH       2   LU result FIFO entries (power of 2, >=2)
//  STARVE_MAX  4   cycles a FIFO head may wait behind WB before WB is stalled
// PORTS
//  clk          in   1       clock; all state on posedge
//  rst_n        in   1       reset, asynchronous, active-low
//  wb_valid     in   1       WB stage holds a register write
//  wb_addr      in   ADDR_W  WB destination register
//  wb_data      in   DATA_W  WB result
//  wb_stall     out  1       WB lost arbitration; pipeline must hold WB and re-present it next cycle
//  lu_valid     in   1       LU result available
//  lu_ready     out  1       FIFO can accept a result (= !full)
//  lu_addr      in   ADDR_W  LU destination register
//  lu_data      in   DATA_W  LU result
//  issue_valid  in   1       long-latency op dispatched this cycle
//  issue_addr   in   ADDR_W  its destination register
//  pending      out  32      scoreboard; bit r=1 means r awaits an LU write
//  rf_we        out  1       to regfile RegWrite
//  rf_waddr     out  ADDR_W  to regfile WriteRegister
//  rf_wdata     out  DATA_W  to regfile WriteData
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FIFO empty, pending=0, starve counter=0, wb_stall=0.
//   - rf_we=0 while rst_n=0; lu_ready=1 once rst_n=1.
//   - Reset mid-operation discards buffered LU results and clears all pending bits.
//  Push: lu_valid && lu_ready -> entry {lu_addr,lu_data} enqueued on this edge.
//  Grant (combinational, same cycle):
//   - wb_stall=0 && wb_valid -> WB drives rf_* (zero latency);
//   - else if FIFO non-empty -> head drives rf_*, popped on this edge.
//  Latency: LU -> regfile write is at least 1 cycle (always through the FIFO, never bypassed).
//  Simultaneous push and pop on a full FIFO is allowed; lu_ready still reflects full, so no push that cycle.
//  XZR (addr 31):
//   - rf_we=0 for any granted write to 31;
//   - LU entries to 31 are still accepted and popped, i.e. dropped;
//   - issue_addr=31 never sets pending.
//  Scoreboard:
//   - set bit issue_addr on issue_valid;
//   - clear bit rf_waddr when an LU entry pops;
//   - same-cycle set and clear of the same bit -> set wins;
//   - WB writes never touch pending.
//  Starvation:
//   - counter increments each cycle the FIFO is non-empty and its head is not granted;
//   - counter resets on any pop.
//   - When the counter reaches STARVE_MAX, wb_stall=1 (registered) for exactly one cycle.
//   - That cycle the FIFO head is granted even if wb_valid=1; the WB write is not performed and must be re-presented.
//   - The counter returns to 0 after that pop.
//  Widths: FIFO pointers are clog2(DEPTH)+1 bits with wrap bit; full = ptrs equal except MSB.
// STRUCTURE
//  regfile_pkg: DATA_W/ADDR_W defaults, localparam XZR=5'd31, typedef struct packed {addr,data} rf_wr_t.
//  Sub-module wr_fifo #(DEPTH) (sync FIFO of rf_wr_t, push/pop/full/empty).
//  Arbiter, starve counter and scoreboard stay in this module.
// TESTING
//  1. WB only: wb_valid=1, addr=3, data=0xAA -> rf_we=1, rf_waddr=3, rf_wdata=0xAA same cycle; no wb_stall.
//  2. LU into idle port: issue addr 7 -> pending[7]=1; lu push {7,0x55} cycle 0 -> rf write of 7 in cycle 1 -> pending[7]=0 in cycle 2.
//  3. Backpressure: wb_valid held 1, three LU pushes (DEPTH=2) -> third sees lu_ready=0.
//     After 4 waiting cycles, wb_stall=1 for one cycle and the head drains.
//  4. XZR: lu push {31,0xFF} and issue_addr=31 -> rf_we=0 at drain; entry popped; pending stays 0.
//  5. Re-issue race: pending[9] pops in the same cycle issue_addr=9 -> pending[9]=1 afterwards.
//  6. Reset with 2 entries queued and pending=0x0000_0300 -> all cleared, rf_we=0, lu_ready=1 after release.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: default widths, the XZR
// register index and the buffered write record.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// Synchronous FIFO of pending LU register writes; pointers carry a wrap bit
// so full and empty are distinguishable without a separate count.
module wr_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  rf_wr_t din_i,
    input  logic   pop_i,
    output rf_wr_t dout_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, rd_q;
    rf_wr_t      mem_q [DEPTH];

    logic do_push, do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between the WB stage and the buffered LU,
// with a starvation guard and a scoreboard of registers awaiting LU results.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [31:0]       pending,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    rf_wr_t  head;
    logic    fifo_full, fifo_empty, push, grant_lu, grant_wb;
    logic    stall_q, stall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_q, pend_d;

    assign lu_ready = rst_n && !fifo_full;
    assign push     = lu_valid && lu_ready;
    assign wb_stall = stall_q;
    assign pending  = pend_q;

    // A starvation stall hands the port to the FIFO head even with WB valid.
    assign grant_wb = wb_valid && !stall_q;
    assign grant_lu = !fifo_empty && !grant_wb;

    wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ('{addr: lu_addr, data: lu_data}),
        .pop_i   (grant_lu),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        rf_waddr = head.addr;
        rf_wdata = head.data;
        if (grant_wb) begin
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
        end
        rf_we = rst_n && (grant_wb || grant_lu) && (rf_waddr != XZR);
    end

    always_comb begin
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        if (grant_lu) begin
            cnt_d = '0;
        end else if (!fifo_empty) begin
            cnt_d   = cnt_q + 1'b1;
            stall_d = (int'(cnt_q) + 1 == STARVE_MAX);
        end
    end

    // Set is applied after clear so a re-issue racing the pop keeps the bit.
    always_comb begin
        pend_d = pend_q;
        if (grant_lu) pend_d[head.addr] = 1'b0;
        if (issue_valid && issue_addr != XZR) pend_d[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        wb_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [63:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [31:0] pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5), .DEPTH(2), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_stall    (wb_stall),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_addr     (lu_addr),
        .lu_data     (lu_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .pending     (pending),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1ns after the edge, then let inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h1;
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
        issue_valid = 1'b0; issue_addr = '0;
        #2;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pending", pending, 0);
        chk("rst_wb_stall", wb_stall, 0);
        wb_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1 chk("rst_lu_ready", lu_ready, 1);

        // 1. WB only, zero latency
        tick();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'hAA;
        #1;
        chk("t1_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 3);
        chk("t1_wdata", rf_wdata, 64'hAA);
        chk("t1_stall", wb_stall, 0);
        tick();
        wb_valid = 1'b0;

        // 2. LU into idle port, scoreboard set/clear
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("t2_pend_set", pending, 32'h80);
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 64'h55;
        #1;
        chk("t2_no_bypass", rf_we, 0);
        chk("t2_ready", lu_ready, 1);
        tick();
        lu_valid = 1'b0;
        #1;
        chk("t2_we", rf_we, 1);
        chk("t2_waddr", rf_waddr, 7);
        chk("t2_wdata", rf_wdata, 64'h55);
        chk("t2_pend_hold", pending, 32'h80);
        tick();
        chk("t2_pend_clr", pending, 0);
        chk("t2_idle", rf_we, 0);

        // 3. Backpressure and starvation
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 64'h11;
        lu_valid = 1'b1; lu_addr = 5'd2; lu_data = 64'h22;
        #1;
        chk("t3_c0_waddr", rf_waddr, 1);
        chk("t3_c0_stall", wb_stall, 0);
        tick();
        lu_addr = 5'd4; lu_data = 64'h44;
        #1 chk("t3_c1_ready", lu_ready, 1);
        tick();
        lu_addr = 5'd6; lu_data = 64'h66;
        #1 chk("t3_c2_ready", lu_ready, 0);
        tick();
        lu_valid = 1'b0;
        #1 chk("t3_c3_stall", wb_stall, 0);
        tick();
        chk("t3_c4_stall", wb_stall, 0);
        chk("t3_c4_waddr", rf_waddr, 1);
        tick();
        chk("t3_c5_stall", wb_stall, 1);
        chk("t3_c5_we", rf_we, 1);
        chk("t3_c5_waddr", rf_waddr, 2);
        chk("t3_c5_wdata", rf_wdata, 64'h22);
        tick();
        chk("t3_c6_stall", wb_stall, 0);
        chk("t3_c6_waddr", rf_waddr, 1);
        chk("t3_c6_ready", lu_ready, 1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("t3_c7_waddr", rf_waddr, 4);
        chk("t3_c7_wdata", rf_wdata, 64'h44);
        chk("t3_c7_stall", wb_stall, 0);
        tick();
        chk("t3_c8_idle", rf_we, 0);

        // 4. XZR: dropped write, no pending bit
        issue_valid = 1'b1; issue_addr = 5'd31;
        lu_valid = 1'b1; lu_addr = 5'd31; lu_data = 64'hFF;
        tick();
        issue_valid = 1'b0;
        lu_addr = 5'd5; lu_data = 64'h5A;
        #1;
        chk("t4_xzr_we", rf_we, 0);
        chk("t4_xzr_pend", pending, 0);
        tick();
        lu_valid = 1'b0;
        #1;
        chk("t4_next_we", rf_we, 1);
        chk("t4_next_waddr", rf_waddr, 5);
        tick();

        // 5. Re-issue racing the pop
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("t5_pend_set", pending, 32'h200);
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 64'h99;
        tick();
        lu_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 5'd9;
        #1 chk("t5_pop_waddr", rf_waddr, 9);
        tick();
        issue_valid = 1'b0;
        chk("t5_set_wins", pending, 32'h200);

        // 6. Reset mid-operation
        issue_valid = 1'b1; issue_addr = 5'd8;
        tick();
        issue_valid = 1'b0;
        chk("t6_pend", pending, 32'h300);
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 64'h7;
        lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 64'h88;
        tick();
        lu_addr = 5'd9; lu_data = 64'h99;
        tick();
        lu_valid = 1'b0;
        #1 chk("t6_full", lu_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pend", pending, 0);
        chk("t6_rst_we", rf_we, 0);
        chk("t6_rst_stall", wb_stall, 0);
        tick();
        wb_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t6_ready", lu_ready, 1);
        chk("t6_empty", rf_we, 0);
        chk("t6_pend_after", pending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
